// File: rtl/gate_adder_pkg.sv
// Purpose: shared constants and types for the gate-level ripple-carry adder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: default/maximum operand width and the carry-chain element type.
package gate_adder_pkg;

    localparam int GATE_ADDER_DEFAULT_WIDTH = 1;
    localparam int GATE_ADDER_MAX_WIDTH     = 64;

    // One link of the ripple carry chain. The top declares the chain as a packed
    // vector of these, sized [WIDTH:0], so no bit of a max-width vector dangles.
    typedef logic carry_bit_t;

endpackage

// File: rtl/gate_full_adder_cell.sv
// Purpose: one-bit full adder built from xor/and/or gate primitives.
// Latency: combinational, zero cycles.
// Backpressure: none; a pure function of its inputs.
//
// Ports:
//   i_a, i_b  operand bits
//   i_cin     carry in
//   o_s       sum bit   = a ^ b ^ cin
//   o_cout    carry out = (a & b) | (cin & (a ^ b))
module gate_full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_prop;
    logic w_gen;
    logic w_pass;

    xor u_xor_prop (w_prop, i_a, i_b);
    xor u_xor_sum  (o_s, w_prop, i_cin);
    and u_and_gen  (w_gen, i_a, i_b);
    and u_and_pass (w_pass, i_cin, w_prop);
    or  u_or_cout  (o_cout, w_gen, w_pass);

endmodule

// File: rtl/gate_adder.sv
// Purpose: WIDTH-bit ripple-carry adder of gate-level cells, outputs registered.
// Latency: 1 cycle from a/b/ci sampled at edge N to sum/co after edge N.
// Backpressure: none; a new operand set is accepted every cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; clears sum, co (and ovf)
//   a, b       WIDTH-bit unsigned operands
//   ci         carry into bit 0
//   sum        registered sum bits
//   co         registered carry out of the MSB
//   ovf        registered two's-complement overflow, only when the build macro
//              GATE_ADDER_OVF_EN is defined
// WIDTH legal range: 1..GATE_ADDER_MAX_WIDTH.
module gate_adder
    import gate_adder_pkg::*;
#(
    parameter int WIDTH = GATE_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef GATE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    carry_bit_t [WIDTH:0] w_carry;
    logic [WIDTH-1:0]     w_sum;

    logic [WIDTH-1:0]     r_sum;
    logic                 r_co;

    assign w_carry[0] = ci;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
        gate_full_adder_cell u_cell (
            .i_a    (a[gi]),
            .i_b    (b[gi]),
            .i_cin  (w_carry[gi]),
            .o_s    (w_sum[gi]),
            .o_cout (w_carry[gi+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
            r_co  <= 1'b0;
        end else begin
            r_sum <= w_sum;
            r_co  <= w_carry[WIDTH];
        end
    end

    assign sum = r_sum;
    assign co  = r_co;

`ifdef GATE_ADDER_OVF_EN
    // Signed overflow: carry into the MSB differs from carry out of it.
    // For WIDTH=1 the carry into the MSB is ci itself (w_carry[0]).
    logic r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_carry[WIDTH] ^ w_carry[WIDTH-1];
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_gate_adder.sv
// Purpose: self-checking bench for gate_adder at WIDTH=1, 8 and 16 side by side.
// Latency: expects results one edge after the operands are applied.
// Backpressure: none; operands are applied every cycle without gaps.
module tb_gate_adder;

    logic        clk;
    logic        rst;

    logic        a1, b1, ci1, s1, co1, ov1;
    logic [7:0]  a8, b8, s8;
    logic        ci8, co8, ov8;
    logic [15:0] a16, b16, s16;
    logic        ci16, co16, ov16;

    typedef struct {
        logic [15:0] sum;
        logic        co;
        logic        ovf;
    } exp_t;

    exp_t q1[$];
    exp_t q8[$];
    exp_t q16[$];

    int n_pass  = 0;
    int n_total = 0;

    gate_adder #(.WIDTH(1)) u_dut1 (
        .clk (clk), .rst (rst), .a (a1), .b (b1), .ci (ci1),
        .sum (s1), .co (co1)
`ifdef GATE_ADDER_OVF_EN
        , .ovf (ov1)
`endif
    );

    gate_adder #(.WIDTH(8)) u_dut8 (
        .clk (clk), .rst (rst), .a (a8), .b (b8), .ci (ci8),
        .sum (s8), .co (co8)
`ifdef GATE_ADDER_OVF_EN
        , .ovf (ov8)
`endif
    );

    gate_adder #(.WIDTH(16)) u_dut16 (
        .clk (clk), .rst (rst), .a (a16), .b (b16), .ci (ci16),
        .sum (s16), .co (co16)
`ifdef GATE_ADDER_OVF_EN
        , .ovf (ov16)
`endif
    );

`ifndef GATE_ADDER_OVF_EN
    assign ov1  = 1'b0;
    assign ov8  = 1'b0;
    assign ov16 = 1'b0;
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(int w, longint ua, longint ub, bit c);
        exp_t   e;
        longint modv, half, t, sa, sb, ss;
        modv  = longint'(1) << w;
        half  = modv / 2;
        t     = ua + ub + longint'(c);
        e.sum = 16'(t % modv);
        e.co  = (t >= modv);
        sa    = (ua >= half) ? ua - modv : ua;
        sb    = (ub >= half) ? ub - modv : ub;
        ss    = sa + sb + longint'(c);
        e.ovf = (ss > half - 1) || (ss < -half);
        return e;
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.sum = '0;
        e.co  = 1'b0;
        e.ovf = 1'b0;
        return e;
    endfunction

    task automatic check(string nm, exp_t e, logic [15:0] s, logic c, logic o);
        bit ok;
        n_total++;
        ok = (s === e.sum) && (c === e.co);
`ifdef GATE_ADDER_OVF_EN
        ok = ok && (o === e.ovf);
`endif
        if (ok) n_pass++;
        else $display("FAIL %s @%0t: got sum=%h co=%b ovf=%b, want sum=%h co=%b ovf=%b",
                      nm, $time, s, c, o, e.sum, e.co, e.ovf);
    endtask

    // Apply one operand set to every instance and queue its expected result.
    task automatic drive(bit r,
                         logic x1a, logic x1b, logic x1c,
                         logic [7:0] x8a, logic [7:0] x8b, logic x8c,
                         logic [15:0] x16a, logic [15:0] x16b, logic x16c);
        @(posedge clk);
        #4;
        rst  = r;
        a1   = x1a;  b1  = x1b;  ci1  = x1c;
        a8   = x8a;  b8  = x8b;  ci8  = x8c;
        a16  = x16a; b16 = x16b; ci16 = x16c;
        q1.push_back (r ? zero_exp() : model(1,  longint'(x1a),  longint'(x1b),  x1c));
        q8.push_back (r ? zero_exp() : model(8,  longint'(x8a),  longint'(x8b),  x8c));
        q16.push_back(r ? zero_exp() : model(16, longint'(x16a), longint'(x16b), x16c));
    endtask

    function automatic logic [15:0] r16();
        return 16'($urandom_range(0, 65535));
    endfunction

    // Monitor: outputs are live every cycle, so pop one expectation per instance
    // per cycle, shortly after the edge that produced it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("w1", e, {15'd0, s1}, co1, ov1);
            end
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("w8", e, {8'd0, s8}, co8, ov8);
            end
            if (q16.size() > 0) begin
                e = q16.pop_front();
                check("w16", e, s16, co16, ov16);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1;
        a16 = 16'hFFFF; b16 = 16'hFFFF; ci16 = 1'b1;

        // Reset held two cycles with all-ones inputs: outputs must be zero.
        repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);

        // 1-bit truth sequence alongside 8-bit wrap/overflow corners.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h01, 1'b0, 16'hFFFF, 16'h0001, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h7F, 8'h01, 1'b0, 16'h8000, 16'h8000, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h80, 8'h80, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b1, 16'h0000, 16'h0000, 1'b0);

        // Mid-stream reset: edge with rst gives zero, the next edge the real sum.
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h20, 1'b0, r16(), r16(), 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0, r16(), r16(), 1'b1);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h10, 8'h20, 1'b0, r16(), r16(), 1'b0);

        // Random back-to-back vectors, no idle cycles.
        for (int i = 0; i < 400; i++) begin
            drive(1'b0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                  r16(), r16(), 1'($urandom_range(0, 1)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10; i++) begin
            if (q1.size() == 0 && q8.size() == 0 && q16.size() == 0) break;
            @(posedge clk);
            #3;
        end
        if (q1.size() != 0 || q8.size() != 0 || q16.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d/%0d/%0d results outstanding, want 0/0/0",
                     q1.size(), q8.size(), q16.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
